// File: rtl/sequenciador_jogo_param.sv
// Memory-sequence game controller: plays the ROM sequence for round r, then checks the player's echo.
// Single-cycle state transitions; status outputs decode registered state, nota_saida muxes ROM/buttons by state.
module sequenciador_jogo_param #(
  parameter int N_BOTOES    = 4,
  parameter int MAX_RODADAS = 16,
  parameter int MAX_ERROS   = 3,
  parameter int T_NOTA      = 500,
  parameter int T_PAUSA     = 100,
  parameter int T_JOGADA    = 3000,
  localparam int AW         = $clog2(MAX_RODADAS),
  localparam int EW         = $clog2(MAX_ERROS + 2)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic                treinamento,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic [N_BOTOES-1:0] nota_mem,
  output logic [AW-1:0]       endereco,
  output logic [N_BOTOES-1:0] nota_saida,
  output logic [AW-1:0]       rodada,
  output logic [EW-1:0]       erros,
  output logic                pronto,
  output logic                acertou,
  output logic                db_timeout,
  output logic                db_esgotou,
  output logic [4:0]          db_estado
);

  localparam int T_MAX = (T_JOGADA > T_NOTA) ?
                         ((T_JOGADA > T_PAUSA) ? T_JOGADA : T_PAUSA) :
                         ((T_NOTA > T_PAUSA) ? T_NOTA : T_PAUSA);
  localparam int TW = $clog2(T_MAX + 1);

  typedef enum logic [4:0] {
    INICIAL     = 5'h0,
    PREPARA     = 5'h1,
    TOCA        = 5'h2,
    PAUSA       = 5'h3,
    ESPERA      = 5'h4,
    REGISTRA    = 5'h5,
    SOLTA       = 5'h6,
    COMPARA     = 5'h7,
    PROXIMO     = 5'h8,
    PROX_RODADA = 5'h9,
    ERROU       = 5'hA,
    FIM_ACERTO  = 5'hB,
    FIM_TIMEOUT = 5'hC,
    FIM_ERROS   = 5'hD,
    TREINO      = 5'hE
  } estado_t;

  estado_t             r_estado;
  estado_t             w_estado_prox;
  logic [AW-1:0]       r_rodada;
  logic [AW-1:0]       w_rodada_prox;
  logic [AW-1:0]       r_j;
  logic [AW-1:0]       w_j_prox;
  logic [EW-1:0]       r_erros;
  logic [EW-1:0]       w_erros_prox;
  logic [EW-1:0]       w_erros_inc;
  logic [TW-1:0]       r_timer;
  logic [TW-1:0]       w_timer_prox;
  logic [N_BOTOES-1:0] r_jogada;
  logic [N_BOTOES-1:0] w_jogada_prox;
  logic [N_BOTOES-1:0] r_botoes_ant;
  logic [N_BOTOES-1:0] w_nota;
  logic                w_borda;

  // Only a rising press counts, so a button held into ESPERA needs release and re-press.
  assign w_borda     = (botoes != '0) && (r_botoes_ant == '0);
  assign w_erros_inc = (r_erros == EW'(MAX_ERROS + 1)) ? r_erros : r_erros + EW'(1);

  always_comb begin
    w_estado_prox = r_estado;
    w_rodada_prox = r_rodada;
    w_j_prox      = r_j;
    w_erros_prox  = r_erros;
    w_jogada_prox = r_jogada;
    w_nota        = '0;
    case (r_estado)
      INICIAL: begin
        if (jogar) w_estado_prox = PREPARA;
      end
      PREPARA: begin
        w_rodada_prox = '0;
        w_j_prox      = '0;
        w_erros_prox  = '0;
        w_jogada_prox = '0;
        w_estado_prox = treinamento ? TREINO : TOCA;
      end
      TREINO: begin
        w_nota = botoes;
        if (!treinamento) w_estado_prox = INICIAL;
      end
      TOCA: begin
        w_nota = nota_mem;
        if (r_timer == TW'(T_NOTA - 1)) w_estado_prox = PAUSA;
      end
      PAUSA: begin
        if (r_timer == TW'(T_PAUSA - 1)) begin
          if (r_j == r_rodada) begin
            w_j_prox      = '0;
            w_estado_prox = ESPERA;
          end else begin
            w_j_prox      = r_j + AW'(1);
            w_estado_prox = TOCA;
          end
        end
      end
      ESPERA: begin
        if (w_borda)                            w_estado_prox = REGISTRA;
        else if (r_timer == TW'(T_JOGADA - 1))  w_estado_prox = FIM_TIMEOUT;
      end
      REGISTRA: begin
        w_jogada_prox = botoes;
        w_estado_prox = SOLTA;
      end
      SOLTA: begin
        w_nota = r_jogada;
        if (botoes == '0) w_estado_prox = COMPARA;
      end
      COMPARA: begin
        if (r_jogada != nota_mem)  w_estado_prox = ERROU;
        else if (r_j == r_rodada)  w_estado_prox = PROX_RODADA;
        else                       w_estado_prox = PROXIMO;
      end
      PROXIMO: begin
        w_j_prox      = r_j + AW'(1);
        w_estado_prox = ESPERA;
      end
      PROX_RODADA: begin
        if (r_rodada == AW'(MAX_RODADAS - 1)) begin
          w_estado_prox = FIM_ACERTO;
        end else begin
          w_rodada_prox = r_rodada + AW'(1);
          w_j_prox      = '0;
          w_estado_prox = TOCA;
        end
      end
      ERROU: begin
        w_erros_prox = w_erros_inc;
        if (w_erros_inc > EW'(MAX_ERROS)) begin
          w_estado_prox = FIM_ERROS;
        end else begin
          w_j_prox      = '0;
          w_estado_prox = TOCA;
        end
      end
      FIM_ACERTO, FIM_TIMEOUT, FIM_ERROS: begin
        if (jogar) w_estado_prox = PREPARA;
      end
      default: w_estado_prox = INICIAL;
    endcase
  end

  // One shared timer: it restarts on every state change, so each timed state starts from zero.
  always_comb begin
    w_timer_prox = '0;
    if (w_estado_prox == r_estado)
      w_timer_prox = (r_timer == TW'(T_MAX)) ? r_timer : r_timer + TW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado     <= INICIAL;
      r_rodada     <= '0;
      r_j          <= '0;
      r_erros      <= '0;
      r_timer      <= '0;
      r_jogada     <= '0;
      r_botoes_ant <= '0;
    end else begin
      r_estado     <= w_estado_prox;
      r_rodada     <= w_rodada_prox;
      r_j          <= w_j_prox;
      r_erros      <= w_erros_prox;
      r_timer      <= w_timer_prox;
      r_jogada     <= w_jogada_prox;
      r_botoes_ant <= botoes;
    end
  end

  assign endereco   = r_j;
  assign rodada     = r_rodada;
  assign erros      = r_erros;
  assign nota_saida = w_nota;
  assign db_estado  = r_estado;
  assign acertou    = (r_estado == FIM_ACERTO);
  assign db_timeout = (r_estado == FIM_TIMEOUT);
  assign db_esgotou = (r_estado == FIM_ERROS);
  assign pronto     = acertou | db_timeout | db_esgotou;

endmodule

// File: tb/tb_sequenciador_jogo_param.sv
// Directed bench for sequenciador_jogo_param with a 4-entry ROM {1,2,4,8}.
module tb_sequenciador_jogo_param;

  localparam logic [4:0] S_INICIAL = 5'h0, S_PREPARA = 5'h1, S_TOCA = 5'h2, S_PAUSA = 5'h3,
                         S_ESPERA = 5'h4, S_REGISTRA = 5'h5, S_SOLTA = 5'h6, S_COMPARA = 5'h7,
                         S_PROX_RODADA = 5'h9, S_ERROU = 5'hA, S_FIM_ACERTO = 5'hB,
                         S_FIM_TIMEOUT = 5'hC, S_FIM_ERROS = 5'hD, S_TREINO = 5'hE;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       jogar = 1'b0;
  logic       treinamento = 1'b0;
  logic [3:0] botoes = 4'b0;
  logic [3:0] nota_mem;
  logic [1:0] endereco;
  logic [3:0] nota_saida;
  logic [1:0] rodada;
  logic [1:0] erros;
  logic       pronto, acertou, db_timeout, db_esgotou;
  logic [4:0] db_estado;

  logic [3:0] rom [4];
  int n_cmp = 0;
  int n_err = 0;

  assign nota_mem = rom[endereco];

  sequenciador_jogo_param #(
    .N_BOTOES(4), .MAX_RODADAS(4), .MAX_ERROS(1), .T_NOTA(4), .T_PAUSA(2), .T_JOGADA(20)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .treinamento(treinamento),
    .botoes(botoes), .nota_mem(nota_mem), .endereco(endereco), .nota_saida(nota_saida),
    .rodada(rodada), .erros(erros), .pronto(pronto), .acertou(acertou),
    .db_timeout(db_timeout), .db_esgotou(db_esgotou), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [4:0] s, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (db_estado == s) begin
        ok = 1'b1;
        return;
      end
      step();
    end
    ok = (db_estado == s);
  endtask

  task automatic start_game();
    reset = 1'b0;
    step();
    reset = 1'b1;
    jogar = 1'b1;
    step();
    jogar = 1'b0;
  endtask

  // Returns in COMPARA.
  task automatic press(input logic [3:0] v);
    botoes = v;
    step();
    step();
    botoes = 4'b0;
    step();
  endtask

  task automatic play_round(input int r, output bit ok);
    bit w;
    ok = 1'b1;
    for (int j = 0; j <= r; j++) begin
      wait_state(S_ESPERA, 200, w);
      if (!w) ok = 1'b0;
      press(rom[j]);
    end
    step();
    if (db_estado != S_PROX_RODADA) ok = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({db_estado, nota_saida, endereco, rodada, erros, pronto, acertou, db_timeout, db_esgotou} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: estado=%0h nota=%b rodada=%0d erros=%0d pronto=%b required all 0",
               db_estado, nota_saida, rodada, erros, pronto);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_full_game();
    bit ok;
    int cnt;
    start_game();
    step();
    n_cmp++;
    if (db_estado !== S_TOCA || nota_saida !== 4'b0001) begin
      n_err++;
      $display("FAIL full_first_toca: estado=%0h nota=%b required 2 / 0001", db_estado, nota_saida);
    end
    cnt = 0;
    while (db_estado == S_TOCA && cnt < 50) begin cnt++; step(); end
    n_cmp++;
    if (cnt != 4) begin n_err++; $display("FAIL full_toca_len: got %0d cycles required 4", cnt); end
    cnt = 0;
    while (db_estado == S_PAUSA && cnt < 50) begin cnt++; step(); end
    n_cmp++;
    if (cnt != 2) begin n_err++; $display("FAIL full_pausa_len: got %0d cycles required 2", cnt); end
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j <= r; j++) begin
        wait_state(S_ESPERA, 200, ok);
        n_cmp++;
        if (!ok || rodada !== 2'(r) || endereco !== 2'(j)) begin
          n_err++;
          $display("FAIL full_espera_r%0d_j%0d: estado=%0h rodada=%0d endereco=%0d", r, j, db_estado, rodada, endereco);
        end
        press(rom[j]);
      end
      step();
      n_cmp++;
      if (db_estado !== S_PROX_RODADA) begin
        n_err++;
        $display("FAIL full_prox_rodada_r%0d: estado=%0h required 9", r, db_estado);
      end
      step();
      n_cmp++;
      if (db_estado !== ((r < 3) ? S_TOCA : S_FIM_ACERTO)) begin
        n_err++;
        $display("FAIL full_after_round_r%0d: estado=%0h", r, db_estado);
      end
    end
    n_cmp++;
    if (acertou !== 1'b1 || pronto !== 1'b1 || db_timeout !== 1'b0 || db_esgotou !== 1'b0) begin
      n_err++;
      $display("FAIL full_fim_flags: acertou=%b pronto=%b timeout=%b esgotou=%b required 1 1 0 0",
               acertou, pronto, db_timeout, db_esgotou);
    end
  endtask

  task automatic test_errors();
    bit ok;
    start_game();
    play_round(0, ok);
    wait_state(S_ESPERA, 200, ok);
    press(4'b0001);
    wait_state(S_ESPERA, 20, ok);
    press(4'b0100);
    step();
    n_cmp++;
    if (db_estado !== S_ERROU) begin n_err++; $display("FAIL err1_errou: estado=%0h required A", db_estado); end
    step();
    n_cmp++;
    if (db_estado !== S_TOCA || erros !== 2'd1 || rodada !== 2'd1 || endereco !== 2'd0) begin
      n_err++;
      $display("FAIL err1_replay: estado=%0h erros=%0d rodada=%0d endereco=%0d required 2 1 1 0",
               db_estado, erros, rodada, endereco);
    end
    wait_state(S_ESPERA, 200, ok);
    press(4'b1000);
    step();
    step();
    n_cmp++;
    if (db_estado !== S_FIM_ERROS || db_esgotou !== 1'b1 || pronto !== 1'b1 || erros !== 2'd2 || acertou !== 1'b0) begin
      n_err++;
      $display("FAIL err2_fim: estado=%0h esgotou=%b pronto=%b erros=%0d required D 1 1 2", db_estado, db_esgotou, pronto, erros);
    end
    step();
    step();
    n_cmp++;
    if (db_estado !== S_FIM_ERROS || erros !== 2'd2) begin
      n_err++;
      $display("FAIL err2_hold: estado=%0h erros=%0d required D 2", db_estado, erros);
    end
    jogar = 1'b1;
    step();
    jogar = 1'b0;
    step();
    n_cmp++;
    if (db_estado !== S_TOCA || erros !== 2'd0 || rodada !== 2'd0) begin
      n_err++;
      $display("FAIL err_restart: estado=%0h erros=%0d rodada=%0d required 2 0 0", db_estado, erros, rodada);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt;
    start_game();
    wait_state(S_ESPERA, 200, ok);
    cnt = 0;
    while (db_estado == S_ESPERA && cnt < 100) begin cnt++; step(); end
    n_cmp++;
    if (cnt != 20) begin n_err++; $display("FAIL to_len: got %0d cycles required 20", cnt); end
    n_cmp++;
    if (db_estado !== S_FIM_TIMEOUT || db_timeout !== 1'b1 || pronto !== 1'b1) begin
      n_err++;
      $display("FAIL to_fim: estado=%0h timeout=%b pronto=%b required C 1 1", db_estado, db_timeout, pronto);
    end
    start_game();
    wait_state(S_ESPERA, 200, ok);
    repeat (19) step();
    n_cmp++;
    if (db_estado !== S_ESPERA) begin n_err++; $display("FAIL to_cycle20_still_espera: estado=%0h required 4", db_estado); end
    botoes = 4'b0001;
    step();
    botoes = 4'b0000;
    n_cmp++;
    if (db_estado !== S_REGISTRA) begin n_err++; $display("FAIL to_press_wins: estado=%0h required 5", db_estado); end
  endtask

  task automatic test_multibit_hold();
    bit ok;
    start_game();
    wait_state(S_ESPERA, 200, ok);
    press(4'b0011);
    step();
    n_cmp++;
    if (db_estado !== S_ERROU) begin n_err++; $display("FAIL mb_errou: estado=%0h required A", db_estado); end
    step();
    wait_state(S_PAUSA, 50, ok);
    botoes = 4'b0001;
    wait_state(S_ESPERA, 20, ok);
    repeat (3) step();
    n_cmp++;
    if (!ok || db_estado !== S_ESPERA) begin n_err++; $display("FAIL hold_ignored: estado=%0h required 4", db_estado); end
    botoes = 4'b0000;
    step();
    n_cmp++;
    if (db_estado !== S_ESPERA) begin n_err++; $display("FAIL hold_release: estado=%0h required 4", db_estado); end
    botoes = 4'b0001;
    step();
    n_cmp++;
    if (db_estado !== S_REGISTRA) begin n_err++; $display("FAIL hold_repress: estado=%0h required 5", db_estado); end
    step();
    n_cmp++;
    if (db_estado !== S_SOLTA || nota_saida !== 4'b0001) begin
      n_err++;
      $display("FAIL hold_solta: estado=%0h nota=%b required 6 0001", db_estado, nota_saida);
    end
    botoes = 4'b0000;
    step();
    step();
    n_cmp++;
    if (db_estado !== S_PROX_RODADA) begin n_err++; $display("FAIL hold_correct: estado=%0h required 9", db_estado); end
  endtask

  task automatic test_treino();
    reset = 1'b0;
    step();
    reset = 1'b1;
    treinamento = 1'b1;
    jogar = 1'b1;
    step();
    jogar = 1'b0;
    step();
    n_cmp++;
    if (db_estado !== S_TREINO) begin n_err++; $display("FAIL treino_enter: estado=%0h required E", db_estado); end
    botoes = 4'b0110;
    #1;
    n_cmp++;
    if (nota_saida !== 4'b0110) begin n_err++; $display("FAIL treino_track_a: nota=%b required 0110", nota_saida); end
    botoes = 4'b1000;
    #1;
    n_cmp++;
    if (nota_saida !== 4'b1000) begin n_err++; $display("FAIL treino_track_b: nota=%b required 1000", nota_saida); end
    treinamento = 1'b0;
    botoes = 4'b0000;
    step();
    n_cmp++;
    if (db_estado !== S_INICIAL) begin n_err++; $display("FAIL treino_exit: estado=%0h required 0", db_estado); end
  endtask

  task automatic test_reset_mid_toca();
    bit ok;
    start_game();
    play_round(0, ok);
    play_round(1, ok);
    n_cmp++;
    if (!ok || db_estado !== S_TOCA || rodada !== 2'd2) begin
      n_err++;
      $display("FAIL rst_reach_r2: estado=%0h rodada=%0d required 2 2", db_estado, rodada);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({db_estado, nota_saida, endereco, rodada, erros, pronto, acertou, db_timeout, db_esgotou} !== '0) begin
      n_err++;
      $display("FAIL rst_async: estado=%0h nota=%b rodada=%0d endereco=%0d required all 0",
               db_estado, nota_saida, rodada, endereco);
    end
    #2;
    reset = 1'b1;
    step();
    jogar = 1'b1;
    step();
    jogar = 1'b0;
    step();
    n_cmp++;
    if (db_estado !== S_TOCA || rodada !== 2'd0 || nota_saida !== 4'b0001) begin
      n_err++;
      $display("FAIL rst_restart: estado=%0h rodada=%0d nota=%b required 2 0 0001", db_estado, rodada, nota_saida);
    end
  endtask

  initial begin
    rom[0] = 4'b0001;
    rom[1] = 4'b0010;
    rom[2] = 4'b0100;
    rom[3] = 4'b1000;
    test_reset();
    test_full_game();
    test_errors();
    test_timeout();
    test_multibit_hold();
    test_treino();
    test_reset_mid_toca();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
